// File: rtl/mem_port_arbiter_if.sv
//==============================================================================
// Module      : mem_port_arbiter_if
// Description : Bundle of the fetch requester, data requester and external
//               memory bus signals seen by mem_port_arbiter. The slave
//               modport is the arbiter's view; master is the environment's.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // fetch requester
  logic              i_req;
  logic [AW-1:0]     i_addr;
  logic              i_ready;
  logic [DW-1:0]     i_rdata;
  // data requester
  logic              d_req;
  logic [DW/8-1:0]   d_wen;
  logic [AW-1:0]     d_addr;
  logic [DW-1:0]     d_wdata;
  logic              d_ready;
  logic [DW-1:0]     d_rdata;
  // external memory bus
  logic              m_req;
  logic [DW/8-1:0]   m_wen;
  logic [AW-1:0]     m_addr;
  logic [DW-1:0]     m_wdata;
  logic              m_ack;
  logic [DW-1:0]     m_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_wen, d_addr, d_wdata, m_ack, m_rdata,
    output i_ready, i_rdata, d_ready, d_rdata, m_req, m_wen, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_wen, d_addr, d_wdata, m_ack, m_rdata,
    input  i_ready, i_rdata, d_ready, d_rdata, m_req, m_wen, m_addr, m_wdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
//==============================================================================
// Module      : mem_port_arbiter
// Description : Shares one SRAM-like memory port between the instruction-fetch
//               and data requesters, one transaction at a time.
//               Macro MEM_ARB_RR_EN: defined -> round-robin on a tie,
//               undefined -> fixed priority (data wins a tie).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t state;
  state_t state_next;
  logic   last_grant;
  logic   grant_i;
  logic   grant_d;
  logic   tie_to_d;
  logic   done;

`ifdef MEM_ARB_RR_EN
  // Round-robin: a tie goes to whoever did not own the bus last.
  assign tie_to_d = (last_grant == GRANT_I);
`else
  // Fixed priority: data always wins; history is kept but not consulted.
  assign tie_to_d = 1'b1;
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  // A transaction finishes on the ack of the bus it owns.
  assign done = (state != IDLE) && bus.m_ack;

  // Next-state and grant decode; requests only matter while idle.
  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_req && bus.d_req) begin
          grant_d = tie_to_d;
          grant_i = !tie_to_d;
        end else begin
          grant_i = bus.i_req;
          grant_d = bus.d_req;
        end
        if (grant_i) begin
          state_next = IBUSY;
        end else if (grant_d) begin
          state_next = DBUSY;
        end
      end
      IBUSY, DBUSY: begin
        if (bus.m_ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Bus request registers: load the winner on grant, drop m_req on ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.m_req   <= 1'b0;
      bus.m_wen   <= {(DW/8){1'b0}};
      bus.m_addr  <= {AW{1'b0}};
      bus.m_wdata <= {DW{1'b0}};
    end else if (grant_i) begin
      bus.m_req   <= 1'b1;
      bus.m_wen   <= {(DW/8){1'b0}};
      bus.m_addr  <= bus.i_addr;
    end else if (grant_d) begin
      bus.m_req   <= 1'b1;
      bus.m_wen   <= bus.d_wen;
      bus.m_addr  <= bus.d_addr;
      bus.m_wdata <= bus.d_wdata;
    end else if (done) begin
      bus.m_req   <= 1'b0;
    end
  end

  // Record which requester owned the bus for the round-robin tie-break.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= GRANT_I;
    end else if (done) begin
      last_grant <= (state == DBUSY) ? GRANT_D : GRANT_I;
    end
  end

  // Completion pulses are combinational on the ack; read data passes through.
  assign bus.i_ready = (state == IBUSY) && bus.m_ack;
  assign bus.d_ready = (state == DBUSY) && bus.m_ack;
  assign bus.i_rdata = bus.m_rdata;
  assign bus.d_rdata = bus.m_rdata;

endmodule

`default_nettype wire
